ram_banked_1r1w: RTL
====================

RAM_BANKED_1R1W -- requirements
Module: ram_banked_1r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 11: total word-address width.
REQ-003 SHALL have parameter BANK_ADDR_W, default 10: per-bank address width; NBANK = 2^(ADDR_W-BANK_ADDR_W), and ADDR_W-BANK_ADDR_W must be 0 or more.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds an output register stage.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port w_enb, input, 1 bit: write request.
REQ-008 SHALL have port w_addr, input, ADDR_W bits: write word address.
REQ-009 SHALL have port w_din, input, DATA_W bits: write data.
REQ-010 SHALL have port w_be, input, DATA_W/8 bits: byte write enables.
REQ-011 SHALL have port r_enb, input, 1 bit: read request.
REQ-012 SHALL have port r_addr, input, ADDR_W bits: read word address.
REQ-013 SHALL have port r_dout, output, DATA_W bits: read data.
REQ-014 SHALL have port r_valid, output, 1 bit: r_dout holds the data of a completed read.

Function
REQ-015 SHALL select the bank from addr[ADDR_W-1:BANK_ADDR_W] and the in-bank row from addr[BANK_ADDR_W-1:0].
REQ-016 SHALL write only the addressed bank, and within it only the bytes with w_be[k]=1, on a clk edge where w_enb=1.
REQ-017 SHALL treat w_enb=1 with w_be=0 as a no-op.
REQ-018 SHALL perform a read on a clk edge where r_enb=1, with r_valid=1 and r_dout valid exactly L cycles later; L=1 when OUT_REG=0 and L=2 when OUT_REG=1.
REQ-019 SHALL accept one read per cycle (fully pipelined); back-to-back reads to different banks produce back-to-back valid results.
REQ-020 SHALL register the bank index with each read and use the registered index for the output mux, so r_addr may change freely after the issue edge.
REQ-021 SHALL drive r_dout to 0 whenever r_valid=0.
REQ-022 SHALL, on a write and a read issued on the same edge to different addresses, complete both independently.
REQ-023 SHALL, on a write and a read issued on the same edge to the same address, return the pre-write word (read-first), unless REQ-029 applies.
REQ-024 SHALL leave memory contents undefined after power-up; reset does not clear them.

Reset
REQ-025 SHALL, while rst=0, force r_valid=0, r_dout=0 and all pipeline valid bits to 0 asynchronously.
REQ-026 SHALL ignore writes and reads presented while rst=0.
REQ-027 SHALL discard reads in flight when rst asserts; no r_valid pulse for them appears after rst deasserts.
REQ-028 SHALL accept a read on the first clk edge with rst=1, completing L cycles later.

Configuration
REQ-029 SHALL, with macro RAM_BANKED_BYPASS_EN defined, forward same-address same-edge write data into the read result, per byte: bytes with w_be=1 take w_din and the others take stored data (write-first); without the macro, REQ-023 read-first behaviour holds and no bypass logic is built.

Structure
REQ-030 SHALL place NBANK and the bank/row field widths, as derivation functions or localparams, in shared package ram_pkg.
REQ-031 SHALL instantiate NBANK copies of sub-module ram_bank: a simple dual-port, byte-enabled, registered-read, inferable RAM of 2^BANK_ADDR_W x DATA_W.

Verification
REQ-032 SHALL verify a basic write then read: write 0x11223344 to addr 0x005, then read 0x005 -> r_valid=1 with r_dout=0x11223344 after L cycles.
REQ-033 SHALL verify bank split: write 0xAAAA0000 to 0x005 and 0x5555FFFF to 0x405, then read 0x405 and 0x005 back-to-back -> consecutive valid cycles returning 0x5555FFFF then 0xAAAA0000.
REQ-034 SHALL verify byte enables: preload 0xFFFFFFFF at 0x010, write 0x12345678 with w_be=4'b0101 -> readback 0xFF34FF78.
REQ-035 SHALL verify collision: preload 0x0 at 0x020, then write 0xCAFEBABE with w_be=4'hF and read 0x020 on the same edge -> 0x00000000 without the macro, 0xCAFEBABE with it.
REQ-036 SHALL verify reset mid-operation: issue reads at 0x001 and 0x002 with OUT_REG=1, assert rst one cycle later -> r_valid and r_dout=0 immediately; no valid pulse after release; a fresh read returns the stored data.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared geometry helpers for the banked 1R1W RAM: bank count and the
// bank/row field widths derived from the word and per-bank address widths.
package ram_pkg;

    // Number of banks carved out of the total word-address space.
    function automatic int nbank(input int addr_w, input int bank_addr_w);
        return 1 << (addr_w - bank_addr_w);
    endfunction

    // Bank-index field width; kept at least one bit so the single-bank build still has a signal.
    function automatic int bank_w(input int addr_w, input int bank_addr_w);
        return (addr_w > bank_addr_w) ? (addr_w - bank_addr_w) : 1;
    endfunction

    function automatic int row_w(input int bank_addr_w);
        return bank_addr_w;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One simple dual-port bank: byte-enabled write, registered read (read-first
// on a same-row collision), written so synthesis can map it onto block RAM.
module ram_bank #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 10
) (
    input  logic                clk,
    input  logic                w_en,
    input  logic [ROW_W-1:0]    w_row,
    input  logic [DATA_W-1:0]   w_din,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic                r_en,
    input  logic [ROW_W-1:0]    r_row,
    output logic [DATA_W-1:0]   r_data
);

    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**ROW_W];

    // NOTE: the storage array and its read register carry no reset, otherwise
    // the array cannot be inferred as RAM; validity is tracked outside.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (w_be[k]) mem[w_row][8*k +: 8] <= w_din[8*k +: 8];
            end
        end
        if (r_en) r_data <= mem[r_row];
    end

endmodule

// File: rtl/ram_banked_1r1w.sv
// Banked 1R1W RAM with pipelined reads (latency 1, or 2 with OUT_REG=1).
// Define RAM_BANKED_BYPASS_EN for write-first forwarding on same-address collisions.
module ram_banked_1r1w
    import ram_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 11,
    parameter int BANK_ADDR_W = 10,
    parameter int OUT_REG     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_enb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_din,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic                r_enb,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_dout,
    output logic                r_valid
);

    localparam int NBANK  = nbank(ADDR_W, BANK_ADDR_W);
    localparam int BANK_W = bank_w(ADDR_W, BANK_ADDR_W);
    localparam int ROW_W  = row_w(BANK_ADDR_W);
    localparam int NBYTE  = DATA_W / 8;

    logic [BANK_W-1:0] w_bank, r_bank, bank1;
    logic [ROW_W-1:0]  w_row, r_row;
    logic              w_go, r_go, v1;
    logic [DATA_W-1:0] bank_rd [NBANK];
    logic [DATA_W-1:0] rd_mux, data1;

    // Requests presented during reset are dropped before they reach any bank.
    assign w_go  = w_enb & rst & (|w_be);
    assign r_go  = r_enb & rst;
    assign w_row = w_addr[ROW_W-1:0];
    assign r_row = r_addr[ROW_W-1:0];

    generate
        if (ADDR_W > BANK_ADDR_W) begin : g_split
            assign w_bank = w_addr[ADDR_W-1:BANK_ADDR_W];
            assign r_bank = r_addr[ADDR_W-1:BANK_ADDR_W];
        end else begin : g_single
            assign w_bank = '0;
            assign r_bank = '0;
        end
    endgenerate

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        ram_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk    (clk),
            .w_en   (w_go && (w_bank == BANK_W'(b))),
            .w_row  (w_row),
            .w_din  (w_din),
            .w_be   (w_be),
            .r_en   (r_go && (r_bank == BANK_W'(b))),
            .r_row  (r_row),
            .r_data (bank_rd[b])
        );
    end

    // The bank index travels with the read so r_addr is free after the issue edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            bank1 <= '0;
        end else begin
            v1 <= r_go;
            if (r_go) bank1 <= r_bank;
        end
    end

`ifdef RAM_BANKED_BYPASS_EN
    logic              byp_hit;
    logic [NBYTE-1:0]  byp_be;
    logic [DATA_W-1:0] byp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
        end else begin
            byp_hit  <= r_go && w_go && (w_addr == r_addr);
            byp_be   <= w_be;
            byp_data <= w_din;
        end
    end

    // NOTE: rd_mux gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_mux = bank_rd[bank1];
        if (byp_hit) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (byp_be[k]) rd_mux[8*k +: 8] = byp_data[8*k +: 8];
            end
        end
    end
`else
    assign rd_mux = bank_rd[bank1];
`endif

    assign data1 = v1 ? rd_mux : '0;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    d2 <= data1;
                end
            end

            assign r_valid = v2;
            assign r_dout  = d2;
        end else begin : g_direct
            assign r_valid = v1;
            assign r_dout  = data1;
        end
    endgenerate

endmodule
